// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-bit-per-clock double-dabble binary to packed BCD/excess-3 converter
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_start,
  input  logic [WIDTH-1:0]      in_bin,
  input  logic                  in_xs3,
  output logic                  out_busy,
  output logic                  out_done,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t          state_q;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]   scr_q, scr_d, adj_d, fin_d, bcd_d, bcd_q;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q, ovf_d, xs3_q, busy_q, done_q, ovfo_q;
  always_comb begin
    adj_d = scr_q;
    for (int d = 0; d < DIGITS; d++)
      adj_d[4*d+:4] = scr_q[4*d+:4] >= 4'd5 ? scr_q[4*d+:4] + 4'd3 : scr_q[4*d+:4];
    {scr_d, sr_d} = {adj_d[BW-2:0], sr_q, 1'b0};
    ovf_d = ovf_q | adj_d[BW-1];
    fin_d = scr_d;
    for (int d = 0; d < DIGITS; d++)
      fin_d[4*d+:4] = scr_d[4*d+:4] + (xs3_q ? 4'd3 : 4'd0);
    bcd_d = ovf_d ? (xs3_q ? {DIGITS{4'hC}} : {DIGITS{4'h9}}) : fin_d;
  end
  // DONE also accepts a start so a held in_start yields one result per WIDTH+1 cycles
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      xs3_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovfo_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (in_start) begin
            sr_q    <= in_bin;
            scr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            xs3_q   <= in_xs3;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          sr_q  <= sr_d;
          scr_q <= scr_d;
          ovf_q <= ovf_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= bcd_d;
            ovfo_q  <= ovf_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign out_busy = busy_q;
  assign out_done = done_q;
  assign out_bcd  = bcd_q;
  assign out_ovf  = ovfo_q;
endmodule
